// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared types for the synchronous FIFO.
//   out_state_e : state of the FIFO output stage.
//     OUT_EMPTY - output register holds nothing, no read outstanding.
//     OUT_FETCH - RAM read issued, data lands in the output register next edge.
//     OUT_VALID - output register holds the head entry.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FETCH = 2'd1,
    OUT_VALID = 2'd2
  } out_state_e;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_dpram.sv
// dpram
//   Simple dual-port RAM: one write port, one registered read port.
//   Read data appears on rd_data one clock after rd_addr/rd_en are presented.
//   Contents are not reset. Read-during-write to the same address returns
//   undefined (old or new) data; callers must not depend on it.
// Ports
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   ADDRESS_WIDTH  write address
//   wr_data  in   DATA_WIDTH     write data
//   rd_en    in   read strobe; rd_data holds its value when low
//   rd_addr  in   ADDRESS_WIDTH  read address
//   rd_data  out  DATA_WIDTH     registered read data
module dpram #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port, kept in the classic form so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule : dpram

// File: rtl/sync_fifo.sv
// sync_fifo
//   Synchronous FIFO with valid/ready handshakes on both sides. Entries live in
//   a registered-read dual-port RAM; the head entry is staged into a dedicated
//   output register by a three-state output FSM (EMPTY / FETCH / VALID), so
//   out_data comes straight from a flop.
//   Capacity is DEPTH = 2^ADDRESS_WIDTH entries, counting the output register.
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous clear of all stored entries
//   in_valid   in   producer offers in_data
//   in_data    in   DATA_WIDTH word to push
//   in_ready   out  FIFO accepts a push this cycle (registered)
//   out_valid  out  out_data holds the head entry
//   out_data   out  DATA_WIDTH head entry (registered)
//   out_ready  in   consumer pops the head this cycle
//   level      out  ADDRESS_WIDTH+1 entries held, including the output register
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH:0]   level
);

  localparam logic [ADDRESS_WIDTH:0]   LEVEL_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0]   LEVEL_ONE  = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE    = ADDRESS_WIDTH'(1);

  out_state_e                 state_q,    state_d;
  logic [ADDRESS_WIDTH-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [ADDRESS_WIDTH:0]     level_q,    level_d;
  logic                       in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;

  logic                       push;
  logic                       pop;
  logic                       in_flight;
  logic [ADDRESS_WIDTH:0]     unread;
  logic                       ram_has_entry;
  logic                       issue_read;
  logic [DATA_WIDTH-1:0]      ram_rd_data;

  // Handshakes. A flush cancels any push or pop offered in the same cycle.
  assign push = in_valid & in_ready_q & ~flush;
  assign pop  = (state_q == OUT_VALID) & out_ready & ~flush;

  // Entries still sitting unread in the RAM: everything counted in level
  // except the one already fetched into (or heading for) the output register.
  // Deriving this from level avoids the full/empty ambiguity of equal pointers.
  assign in_flight     = (state_q != OUT_EMPTY);
  assign unread        = level_q - (ADDRESS_WIDTH+1)'(in_flight);
  assign ram_has_entry = (unread != '0);

  // Output-stage FSM, next state. A read is only issued for an entry written
  // on an earlier edge, and a push is refused when every slot is unread, so
  // the read and write addresses of one cycle never coincide.
  always_comb begin
    state_d    = state_q;
    issue_read = 1'b0;
    out_data_d = out_data_q;
    if (flush) begin
      state_d    = OUT_EMPTY;
      out_data_d = '0;
    end else begin
      case (state_q)
        OUT_EMPTY: begin
          if (ram_has_entry) begin
            issue_read = 1'b1;
            state_d    = OUT_FETCH;
          end
        end
        OUT_FETCH: begin
          out_data_d = ram_rd_data;
          state_d    = OUT_VALID;
        end
        OUT_VALID: begin
          if (pop) begin
            if (ram_has_entry) begin
              issue_read = 1'b1;
              state_d    = OUT_FETCH;
            end else begin
              state_d    = OUT_EMPTY;
            end
          end
        end
        default: begin
          state_d = OUT_EMPTY;
        end
      endcase
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (issue_read) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase
    end
    // Ready follows the occupancy after this edge, so a pop frees a slot
    // only from the next cycle on.
    in_ready_d = (level_d < LEVEL_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // in_ready is held low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      out_data_q <= out_data_d;
    end
  end

  dpram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (issue_read),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == OUT_VALID);
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
//   Self-checking bench for sync_fifo with DATA_WIDTH=16, ADDRESS_WIDTH=4.
//   Table-driven cycle vectors, hand-written corner sequences (fill, full with
//   pop, flush, asynchronous reset) and a randomized run against a queue model.
module tb_sync_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   level;

  int n_cmp;
  int n_err;

  sync_fifo #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_irdy;
    logic          e_ovld;
    logic          chk_d;
    logic [DW-1:0] e_od;
    logic [AW:0]   e_lvl;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic fl, logic iv, logic [DW-1:0] id, logic ordy,
                              logic e_irdy, logic e_ovld, logic chk_d,
                              logic [DW-1:0] e_od, logic [AW:0] e_lvl);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.chk_d = chk_d;
    v.e_od = e_od; v.e_lvl = e_lvl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    out_ready = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Pops until n words have left, expecting base, base+1, ...
  task automatic drain(input logic [DW-1:0] base, input int n, input string nm);
    int k;
    int budget;
    k = 0;
    budget = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    while (k < n && budget < 200) begin
      if (out_valid) begin
        chk(nm, 32'(out_data), 32'(base + DW'(k)));
        k++;
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    chk({nm, " count"}, k, n);
  endtask

  initial begin
    logic [DW-1:0] mq [$];
    int            pushed;
    int            lowrun;
    int            cyc;
    logic          exp_rdy;
    logic          do_push;
    logic          do_pop;
    logic [DW-1:0] pdata;

    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset level", 32'(level), 0);
    chk("reset out_data", 32'(out_data), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post-reset in_ready", 32'(in_ready), 1);
    chk("post-reset level", 32'(level), 0);

    // Cycle table: inputs applied, one edge, outputs compared.
    vecs[0]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 5'd1);
    vecs[1]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 5'd1);
    vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 5'd1);
    vecs[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 5'd1);
    vecs[4]  = mk(1'b0, 1'b1, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd1);
    vecs[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd1);
    vecs[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5678, 5'd1);
    vecs[7]  = mk(1'b0, 1'b1, 16'h9ABC, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5678, 5'd2);
    vecs[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd1);
    vecs[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9ABC, 5'd1);
    vecs[10] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0);
    vecs[11] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0);

    for (int i = 0; i < 12; i++) begin
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      tick();
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ovld));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].e_lvl));
      if (vecs[i].chk_d) begin
        chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Fill to capacity, offer one more, then drain in order.
    fill(16, 16'h0000);
    chk("full level", 32'(level), 16);
    chk("full in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 16'h0010;
    tick();
    in_valid = 1'b0;
    chk("17th push level", 32'(level), 16);
    chk("17th push in_ready", 32'(in_ready), 0);
    drain(16'h0000, 16, "full drain");
    chk("full drain level", 32'(level), 0);

    // Full FIFO: simultaneous pop and push offer; only the pop is taken.
    fill(16, 16'h0100);
    chk("full2 out_valid", 32'(out_valid), 1);
    chk("full2 head", 32'(out_data), 32'h0100);
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pop-at-full level", 32'(level), 15);
    chk("pop-at-full in_ready", 32'(in_ready), 1);
    drain(16'h0101, 15, "pop-at-full drain");
    chk("pop-at-full final level", 32'(level), 0);

    // Flush at level 5 together with a push of 0xBEEF.
    fill(5, 16'h0200);
    chk("pre-flush level", 32'(level), 5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush level", 32'(level), 0);
    chk("flush out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post-flush out_valid %0d", i), 32'(out_valid), 0);
    end
    in_valid = 1'b1;
    in_data  = 16'h0042;
    tick();
    in_valid = 1'b0;
    drain(16'h0042, 1, "post-flush first word");
    chk("post-flush level", 32'(level), 0);

    // Asynchronous reset mid-burst at level 7.
    fill(7, 16'h0300);
    chk("pre-reset level", 32'(level), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset level", 32'(level), 0);
    chk("async reset in_ready", 32'(in_ready), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("release in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 16'h00AA;
    tick();
    in_valid = 1'b0;
    chk("AA N out_valid", 32'(out_valid), 0);
    chk("AA N level", 32'(level), 1);
    tick();
    chk("AA N+1 out_valid", 32'(out_valid), 0);
    tick();
    chk("AA N+2 out_valid", 32'(out_valid), 1);
    chk("AA N+2 out_data", 32'(out_data), 32'h00AA);
    drain(16'h00AA, 1, "AA drain");

    // Randomized traffic against a queue model.
    mq.delete();
    pushed = 0;
    lowrun = 0;
    cyc    = 0;
    while ((pushed < 40 || mq.size() != 0) && cyc < 3000) begin
      in_valid  = (pushed < 40) && ($urandom_range(0, 99) < 60);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 99) < 50);
      exp_rdy   = (mq.size() < DEPTH);
      chk("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rnd level", 32'(level), mq.size());
      if (mq.size() == 0) begin
        chk("rnd out_valid when empty", 32'(out_valid), 0);
      end else if (out_valid) begin
        chk("rnd out_data order", 32'(out_data), 32'(mq[0]));
      end
      if (mq.size() != 0 && !out_valid) begin
        lowrun++;
        n_cmp++;
        if (lowrun > 2) begin
          n_err++;
          $display("FAIL rnd head latency: out_valid low %0d cycles with data held, want <=2", lowrun);
        end
      end else begin
        lowrun = 0;
      end
      do_pop  = out_valid && out_ready && (mq.size() != 0);
      do_push = in_valid && exp_rdy;
      pdata   = in_data;
      tick();
      if (do_pop) begin
        void'(mq.pop_front());
      end
      if (do_push) begin
        mq.push_back(pdata);
        pushed++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rnd words pushed", pushed, 40);
    chk("rnd words left", mq.size(), 0);
    tick();
    chk("rnd final level", 32'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FIFO word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, storage address width; DEPTH = 2^ADDRESS_WIDTH entries.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stored entries.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  word to push.
REQ-008 SHALL have port in_ready  output  1  FIFO accepts a push this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds the head entry.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  head entry, registered.
REQ-011 SHALL have port out_ready  input  1  consumer pops the head this cycle.
REQ-012 SHALL have port level  output  ADDRESS_WIDTH+1  entries held, including the output register.

Function
REQ-013 SHALL push in_data when in_valid and in_ready are both high on a rising edge; SHALL pop when out_valid and out_ready are both high.
REQ-014 SHALL drive in_ready = (level < DEPTH), registered; a same-cycle pop SHALL NOT raise in_ready combinationally.
REQ-015 SHALL keep level in 0..DEPTH: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-016 SHALL store entries in a registered-read simple dual-port RAM (one write port, one read port, read data one cycle after address).
REQ-017 SHALL keep write and read pointers of ADDRESS_WIDTH bits, each incrementing modulo DEPTH (DEPTH-1 wraps to 0).
REQ-018 SHALL run an output-stage FSM with states EMPTY, FETCH and VALID.
- EMPTY -> FETCH when the RAM holds at least one unread entry.
- FETCH (read issued, data returns next edge) -> VALID, loading out_data.
- VALID with pop -> FETCH if a further entry is in RAM; -> EMPTY otherwise.
- VALID without pop -> stays in VALID; out_data SHALL stay stable.
REQ-019 SHALL assert out_valid only in VALID.
REQ-020 SHALL, from empty, assert out_valid exactly 2 cycles after the push edge (push at edge N, read at N+1, out_valid at N+2).
REQ-021 SHALL never read a RAM address in the cycle that address is written; read-during-write collision behaviour of the RAM SHALL be irrelevant to correctness.
REQ-022 SHALL sustain one push and one pop per cycle in steady state once level >= 2; a one-cycle bubble after each pop in FETCH is permitted.
REQ-023 SHALL, on flush, zero pointers and level, enter EMPTY, and deassert out_valid next cycle; a push or pop coincident with flush SHALL be discarded.
REQ-024 SHALL preserve strict FIFO order across pointer wrap.

Reset
REQ-025 SHALL, while reset_n is low, asynchronously force pointers=0, level=0, FSM=EMPTY, out_valid=0, out_data=0, in_ready=1 after the first edge following release (0 while in reset).
REQ-026 SHALL, on reset mid-operation, discard all contents; RAM contents need not be cleared.

Structure
REQ-027 SHALL instantiate exactly one sub-module, the team dual-port RAM dpram, with DATA_WIDTH and ADDRESS_WIDTH passed through.
REQ-028 SHALL place the FSM state encoding (EMPTY, FETCH, VALID) in the shared package as an enumerated typedef; no other package contents.

Verification (DATA_WIDTH=16, ADDRESS_WIDTH=4, DEPTH=16)
REQ-029 SHALL check: push 0x1234 into empty FIFO at edge N -> out_valid=1, out_data=0x1234 at N+2; level=1 from N+1.
REQ-030 SHALL check: 16 pushes 0x0000..0x000F with out_ready=0 -> level=16, in_ready=0; 17th in_valid ignored; pops return 0x0000..0x000F in order.
REQ-031 SHALL check: 40 random words with random in_valid/out_ready -> output sequence equals input sequence across 2+ pointer wraps; level never exceeds 16.
REQ-032 SHALL check: level=16 with simultaneous pop and in_valid -> pop taken, push refused, level=15, in_ready=1 next cycle.
REQ-033 SHALL check: level=5, flush asserted alongside push 0xBEEF -> next cycle level=0, out_valid=0; 0xBEEF never appears at output.
REQ-034 SHALL check: reset_n dropped mid-burst at level=7 -> out_valid=0, level=0 immediately; after release, first push 0x00AA emerges 2 cycles later.
